// File: rtl/pll_ctrl_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
// State encoding is exported as status, so it is fixed.
package pll_ctrl_pkg;

  localparam int STATE_W            = 3;
  localparam int DEF_RST_CYCLES     = 16;
  localparam int DEF_LOCK_TIMEOUT   = 12500;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES    = 7;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_LOSS_W         = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RST_ASSERT = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABILIZE  = 3'd2,
    ST_LOCKED     = 3'd3,
    ST_FAILED     = 3'd4
  } pll_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer; 2-edge latency, no flow control.
// Usable for any slow asynchronous status input.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset and qualifies lock on refclk; outputs decode straight from state.
// Lock qualifies 2+STABLE_CYCLES edges after first sampling; no backpressure, requests are single pulses.
module pll_lock_supervisor
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int LOSS_W        = DEF_LOSS_W
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               sw_reset_req,
  input  logic               clear_fail,
  output logic               pll_rst,
  output logic               clk_ready,
  output logic               fail,
  output logic [STATE_W-1:0] state,
  output logic [3:0]         retry_cnt,
  output logic [LOSS_W-1:0]  loss_cnt
);

  pll_state_t        cur_state, nxt_state;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [3:0]        retry_d;
  logic [LOSS_W-1:0] loss_d;
  logic              locked_s;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= ST_RST_ASSERT;
      timer_q   <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      cur_state <= nxt_state;
      timer_q   <= timer_d;
      retry_cnt <= retry_d;
      loss_cnt  <= loss_d;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    timer_d   = timer_q + CNT_W'(1);
    retry_d   = retry_cnt;
    loss_d    = loss_cnt;

    // A software restart outranks everything, including a simultaneous lock drop.
    if (sw_reset_req) begin
      nxt_state = ST_RST_ASSERT;
      timer_d   = '0;
      if (cur_state == ST_FAILED) retry_d = '0;
    end else begin
      case (cur_state)
        ST_RST_ASSERT: begin
          if (timer_q == CNT_W'(RST_CYCLES - 1)) begin
            nxt_state = ST_WAIT_LOCK;
            timer_d   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            nxt_state = ST_STABILIZE;
            timer_d   = '0;
          end else if (timer_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            timer_d = '0;
            if (retry_cnt == 4'(MAX_RETRIES)) begin
              nxt_state = ST_FAILED;
            end else begin
              nxt_state = ST_RST_ASSERT;
              retry_d   = retry_cnt + 4'd1;
            end
          end
        end
        ST_STABILIZE: begin
          // A dropout here is a glitch: re-qualify without resetting the PLL.
          if (!locked_s) begin
            nxt_state = ST_WAIT_LOCK;
            timer_d   = '0;
          end else if (timer_q == CNT_W'(STABLE_CYCLES - 1)) begin
            nxt_state = ST_LOCKED;
            timer_d   = '0;
            retry_d   = '0;
          end
        end
        ST_LOCKED: begin
          timer_d = '0;
          if (!locked_s) begin
            nxt_state = ST_RST_ASSERT;
            if (loss_cnt != '1) loss_d = loss_cnt + LOSS_W'(1);
          end
        end
        ST_FAILED: begin
          timer_d = '0;
          if (clear_fail) begin
            nxt_state = ST_RST_ASSERT;
            retry_d   = '0;
          end
        end
        default: begin
          nxt_state = ST_RST_ASSERT;
          timer_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pll_rst   = 1'b0;
    clk_ready = 1'b0;
    fail      = 1'b0;
    case (cur_state)
      ST_RST_ASSERT: pll_rst = 1'b1;
      ST_LOCKED:     clk_ready = 1'b1;
      ST_FAILED: begin
        pll_rst = 1'b1;
        fail    = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = cur_state;

endmodule
